// File: rtl/alu_issue_seq.sv
// alu_issue_seq: instruction sequencer in front of a combinational ALU.
// Accepts one instruction word at a time, reads the 8-entry register file,
// issues registered operands/opcode to the ALU and writes the result back.
// MAC is run as MUL followed by ADD; DIV by zero never reaches the ALU;
// BEQ/BNE resolve a branch from bit 0 of the ALU result.
//
// Optional build macro: ALU_ISSUE_SEQ_DIVZERO_TRAP_EN
//   defined   -> adds sticky 'err' output; DIV by zero sets err and skips writeback
//   undefined -> DIV by zero writes 0 to rd
//
// Handshake: an instruction is taken on a rising edge where
// instr_valid && instr_ready. instr_ready is high only while the sequencer is
// idle and not pulsing done. The source holds instr stable until taken.

module alu_issue_seq #(
    parameter int DW   = 19,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    input  logic [18:0]   instr,
    output logic          instr_ready,
    output logic [DW-1:0] alu_op1,
    output logic [DW-1:0] alu_op2,
    output logic [4:0]    alu_opcode,
    input  logic [DW-1:0] alu_result,
    output logic          done,
    output logic          branch_taken,
    output logic [7:0]    branch_target,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
`ifdef ALU_ISSUE_SEQ_DIVZERO_TRAP_EN
    ,
    output logic          err
`endif
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_MAC = 5'b01000;
    localparam logic [4:0] OP_UNS = 5'b01110;
    localparam logic [4:0] OP_BEQ = 5'b01111;
    localparam logic [4:0] OP_BNE = 5'b10000;
    localparam logic [4:0] OP_DEF = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_EX   = 3'd2,
        S_EX2  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] regs [NREG];

    logic [4:0]    op_q;
    logic [2:0]    rd_q;
    logic [2:0]    rs1_q;
    logic [2:0]    rs2_q;
    logic [4:0]    tgt_q;
    logic [DW-1:0] rs1_val;
    logic [DW-1:0] rs2_val;
    logic [DW-1:0] rd_val;
    logic          divz_q;
    logic          br_q;
    logic [DW-1:0] res_q;

    logic          accept;
    logic          is_mac;
    logic          is_br;
    logic          is_uns;
    logic          wr_en;
    logic [DW-1:0] res_nxt;

    // Decode of the captured opcode and the value retired in WB
    always_comb begin
        is_mac  = (op_q == OP_MAC);
        is_br   = (op_q == OP_BEQ) || (op_q == OP_BNE);
        is_uns  = (op_q == OP_UNS) || (op_q > OP_BNE);
        res_nxt = divz_q ? '0 : alu_result;
        wr_en   = !is_br && !is_uns && (rd_q != 3'd0);
`ifdef ALU_ISSUE_SEQ_DIVZERO_TRAP_EN
        if (divz_q) wr_en = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: MAC takes the extra EX2 pass
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RD;
            S_RD:    state_nxt = S_EX;
            S_EX:    state_nxt = is_mac ? S_EX2 : S_WB;
            S_EX2:   state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state and registered flags
    always_comb begin
        instr_ready  = (state == S_IDLE) && !done;
        accept       = instr_valid && instr_ready;
        branch_taken = done && br_q && res_q[0];
        dbg_data     = (dbg_addr == 3'd0) ? '0 : regs[dbg_addr];
    end

    // Datapath: capture, operand read, ALU issue, writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            op_q          <= '0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            tgt_q         <= '0;
            rs1_val       <= '0;
            rs2_val       <= '0;
            rd_val        <= '0;
            divz_q        <= 1'b0;
            br_q          <= 1'b0;
            res_q         <= '0;
            alu_op1       <= '0;
            alu_op2       <= '0;
            alu_opcode    <= OP_DEF;
            done          <= 1'b0;
            branch_target <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= instr[18:14];
                        rd_q  <= instr[13:11];
                        rs1_q <= instr[10:8];
                        rs2_q <= instr[7:5];
                        tgt_q <= instr[4:0];
                    end
                end
                S_RD: begin
                    rs1_val <= regs[rs1_q];
                    rs2_val <= regs[rs2_q];
                    rd_val  <= regs[rd_q];
                end
                S_EX: begin
                    // A zero divisor never reaches the ALU; opcode keeps its old value
                    if ((op_q == OP_DIV) && (rs2_val == '0)) begin
                        divz_q <= 1'b1;
                    end else begin
                        divz_q     <= 1'b0;
                        alu_op1    <= rs1_val;
                        alu_op2    <= rs2_val;
                        alu_opcode <= is_mac ? OP_MUL : op_q;
                    end
                end
                S_EX2: begin
                    // Second MAC pass: product from the ALU plus the old rd value
                    alu_op1    <= alu_result;
                    alu_op2    <= rd_val;
                    alu_opcode <= OP_ADD;
                end
                S_WB: begin
                    res_q <= res_nxt;
                    br_q  <= is_br;
                    done  <= 1'b1;
                    if (is_br) branch_target <= {rd_q, tgt_q};
                    if (wr_en) regs[rd_q] <= res_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ISSUE_SEQ_DIVZERO_TRAP_EN
    // Sticky divide-by-zero flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         err <= 1'b0;
        else if (state == S_WB && divz_q) err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural ALU model. Register
// contents are seeded by letting the model ALU return a chosen value for an
// ADD from r0. Expected retire results are queued at accept time and popped
// when done pulses.
module tb_alu_issue_seq;

  localparam int DW = 19;
  localparam int W  = 1 + 8 + 3 + DW;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_MAC = 5'b01000;
  localparam logic [4:0] OP_BEQ = 5'b01111;
  localparam logic [4:0] OP_BNE = 5'b10000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic [18:0]   instr = '0;
  logic          instr_ready;
  logic [DW-1:0] alu_op1;
  logic [DW-1:0] alu_op2;
  logic [4:0]    alu_opcode;
  logic [DW-1:0] alu_result;
  logic          done;
  logic          branch_taken;
  logic [7:0]    branch_target;
  logic [2:0]    dbg_addr = '0;
  logic [DW-1:0] dbg_data;
`ifdef ALU_ISSUE_SEQ_DIVZERO_TRAP_EN
  logic          err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] model [8];

  logic          inject_en = 1'b0;
  logic [DW-1:0] inject_val = '0;
  logic [2*DW-1:0] prod;

  int            acc_t;
  int            done_cyc;
  logic [4:0]    opc2, opc3;
  logic [DW-1:0] op1_3, op2_3;

  alu_issue_seq dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .done(done),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_ISSUE_SEQ_DIVZERO_TRAP_EN
    , .err(err)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural combinational ALU
  always_comb begin
    prod = alu_op1 * alu_op2;
    case (alu_opcode)
      OP_ADD:  alu_result = alu_op1 + alu_op2;
      OP_SUB:  alu_result = alu_op1 - alu_op2;
      OP_MUL:  alu_result = prod[DW-1:0];
      OP_DIV:  alu_result = (alu_op2 == '0) ? '0 : alu_op1 / alu_op2;
      OP_BEQ:  alu_result = {{(DW-1){1'b0}}, alu_op1 == alu_op2};
      OP_BNE:  alu_result = {{(DW-1){1'b0}}, alu_op1 != alu_op2};
      default: alu_result = '0;
    endcase
    if (inject_en) alu_result = inject_val;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present an instruction, wait for accept, queue expected result
  task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [4:0] tgt);
    int n;
    logic [DW-1:0] a, b, res;
    logic br, uns, wr, taken;
    instr = {op, rd, rs1, rs2, tgt};
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    acc_t = cyc - 1;
    instr_valid = 1'b0;
    // reference model of the retire effect
    a = model[rs1];
    b = model[rs2];
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_MUL:  res = DW'(a * b);
      OP_DIV:  res = (b == '0) ? '0 : a / b;
      OP_MAC:  res = DW'(a * b) + model[rd];
      OP_BEQ:  res = {{(DW-1){1'b0}}, a == b};
      OP_BNE:  res = {{(DW-1){1'b0}}, a != b};
      default: res = '0;
    endcase
    if (inject_en && op != OP_MAC) res = inject_val;
    br  = (op == OP_BEQ) || (op == OP_BNE);
    uns = (op == 5'b01110) || (op > OP_BNE);
    wr  = !br && !uns && (rd != 3'd0);
`ifdef ALU_ISSUE_SEQ_DIVZERO_TRAP_EN
    if (op == OP_DIV && b == '0) wr = 1'b0;
`endif
    if (wr) model[rd] = res;
    taken = br && res[0];
    exp_q.push_back({taken, rd, tgt, rd, model[rd]});
  endtask

  // wait for done, sample issue trace, pop and compare the scoreboard
  task automatic wait_done(input int exp_lat);
    int k;
    logic got;
    logic [W-1:0] e;
    k = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(posedge clk); #1; k++;
      if (k == 1) check("ready_busy", instr_ready, 1'b0);
      if (k == 2) opc2 = alu_opcode;
      if (k == 3) begin opc3 = alu_opcode; op1_3 = alu_op1; op2_3 = alu_op2; end
      if (done) got = 1'b1;
    end
    check("done_seen", got, 1'b1);
    done_cyc = cyc;
    check("done_latency", done_cyc - acc_t, exp_lat);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("branch_taken", branch_taken, e[W-1]);
      if (e[W-1]) check("branch_target", branch_target, e[W-2 -: 8]);
      dbg_addr = e[DW+2:DW];
      #1;
      check("rd_value", dbg_data, e[DW-1:0]);
    end
  endtask

  task automatic seed(input logic [2:0] rd, input logic [DW-1:0] v);
    inject_en = 1'b1;
    inject_val = v;
    issue(OP_ADD, rd, 3'd0, 3'd0, 5'd0);
    wait_done(4);
    inject_en = 1'b0;
  endtask

  initial begin
    logic [4:0] prev_opc;
    for (int i = 0; i < 8; i++) model[i] = '0;

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_ready", instr_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_opcode", alu_opcode, 5'b11111);
    check("rst_op1", alu_op1, 0);
    check("rst_op2", alu_op2, 0);
    check("rst_btarget", branch_target, 0);
    dbg_addr = 3'd1; #1;
    check("rst_r1", dbg_data, 0);

    // ADD r1 = r2 + r3
    seed(3'd2, 19'd5);
    seed(3'd3, 19'd7);
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 5'd0);
    wait_done(4);
    check("add_opcode", opc2, OP_ADD);

    // MAC r4 = r1*r2 + r4
    seed(3'd1, 19'd3);
    seed(3'd2, 19'd4);
    seed(3'd4, 19'd10);
    issue(OP_MAC, 3'd4, 3'd1, 3'd2, 5'd0);
    wait_done(5);
    check("mac_pass1_opcode", opc2, OP_MUL);
    check("mac_pass2_opcode", opc3, OP_ADD);
    check("mac_pass2_op1", op1_3, 19'd12);
    check("mac_pass2_op2", op2_3, 19'd10);

    // DIV r5 = r1 / r0 : ALU not issued
    seed(3'd5, 19'd9);
    prev_opc = alu_opcode;
    issue(OP_DIV, 3'd5, 3'd1, 3'd0, 5'd0);
    wait_done(4);
    check("divz_opcode_held", opc2, prev_opc);
`ifdef ALU_ISSUE_SEQ_DIVZERO_TRAP_EN
    check("divz_err", err, 1'b1);
`endif

    // BEQ / BNE r1, r1, rd=3, tgt 0x0A
    issue(OP_BEQ, 3'd3, 3'd1, 3'd1, 5'h0A);
    wait_done(4);
    check("beq_target_const", branch_target, 8'h6A);
    issue(OP_BNE, 3'd3, 3'd1, 3'd1, 5'h0A);
    wait_done(4);

    // write to r0 is dropped; unsupported opcode retires without writeback
    issue(OP_SUB, 3'd0, 3'd1, 3'd2, 5'd0);
    wait_done(4);
    issue(5'b10101, 3'd1, 3'd2, 3'd3, 5'd0);
    wait_done(4);

    // valid held while busy: second instruction waits until after done
    issue(OP_ADD, 3'd7, 3'd1, 3'd1, 5'd0);
    instr = {OP_SUB, 3'd6, 3'd1, 3'd2, 5'd0};
    instr_valid = 1'b1;
    wait_done(4);
    check("ready_in_done_cycle", instr_ready, 1'b0);
    begin
      int first_done;
      first_done = done_cyc;
      issue(OP_SUB, 3'd6, 3'd1, 3'd2, 5'd0);
      check("accept_after_done", acc_t, first_done + 1);
    end
    wait_done(4);

    // truncation on add
    seed(3'd2, 19'h7FFFF);
    seed(3'd3, 19'd2);
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 5'd0);
    wait_done(4);

    // reset during EX of ADD r1
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 5'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_done", done, 1'b0);
    check("midrst_opcode", alu_opcode, 5'b11111);
    check("midrst_op1", alu_op1, 0);
    dbg_addr = 3'd1; #1;
    check("midrst_r1", dbg_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_ready", instr_ready, 1'b1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (done) seen++;
      end
      check("midrst_no_done", seen, 0);
    end
    void'(exp_q.pop_front());
    for (int i = 0; i < 8; i++) model[i] = '0;
    dbg_addr = 3'd2; #1;
    check("midrst_r2", dbg_data, 0);

    // sequencer still works after the abort
    seed(3'd2, 19'd21);
    issue(OP_ADD, 3'd3, 3'd2, 3'd2, 5'd0);
    wait_done(4);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Instruction sequencer that drives the 19-bit combinational ALU: accepts instruction words, reads an internal 8x19 register file, presents operands and opcode to the ALU, captures the result and writes it back.
- Sits between the fetch stage and the ALU. It is the initiating end of the ALU's op1/op2/opcode -> result interface.
- Handles two-pass MAC, divide-by-zero guarding and BEQ/BNE branch resolution.

Parameters:
- DW, 19, datapath width; must match the ALU operand width.
- NREG, 8, register count; register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction word valid
- instr  in  19  instruction word: [18:14] opcode, [13:11] rd, [10:8] rs1, [7:5] rs2, [4:0] tgt_lo
- instr_ready  out  1  sequencer idle, can accept an instruction
- alu_op1  out  DW  ALU operand 1 (registered)
- alu_op2  out  DW  ALU operand 2 (registered)
- alu_opcode  out  5  ALU opcode (registered)
- alu_result  in  DW  ALU combinational result
- done  out  1  one-cycle pulse when the instruction retires
- branch_taken  out  1  one-cycle pulse with done when BEQ/BNE resolves true
- branch_target  out  8  {rd, tgt_lo}; valid while branch_taken is high
- dbg_addr  in  3  register file debug read address
- dbg_data  out  DW  combinational register read; 0 when dbg_addr = 0

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: state IDLE, all registers 0, alu_op1/alu_op2 0, alu_opcode 5'b11111 (maps to ALU default), done 0, branch_taken 0, branch_target 0. instr_ready reads 1 once rst deasserts.
- States: IDLE -> RD -> EX -> (EX2 for MAC) -> WB -> IDLE.
- instr_ready is high only in IDLE. The instruction is captured on the cycle where instr_valid && instr_ready.
- RD: latch rs1_val, rs2_val and rd_val from the register file.
- EX: drive alu_op1 = rs1_val, alu_op2 = rs2_val, alu_opcode = opcode. At the end of the next cycle, register alu_result into res_q. The ALU output is therefore sampled one cycle after the registered inputs change.
- MAC (01000): the ALU MAC opcode is never issued.
  - EX issues MUL (00010) with rs1_val and rs2_val.
  - EX2 issues ADD (00000) with op1 = product and op2 = rd_val.
  - Result is rd <= rs1*rs2 + rd, truncated to DW bits.
- DIV (00011) with rs2_val = 0: the ALU is not issued (alu_opcode stays at its previous value) and res_q = 0.
- BEQ (01111) / BNE (10000):
  - No writeback.
  - In WB, done pulses.
  - branch_taken = res_q[0], and branch_target is driven.
- Unsupported opcodes (01110, 10001-11111): no writeback; done pulses; branch_taken stays 0.
- All other opcodes: in WB, rd <= res_q if rd != 0, then done pulses.
- Latency: accept at cycle T, done at T+4. MAC: done at T+5. The next instruction can be accepted in the cycle after done.
- Arithmetic: all results are truncated to DW bits; no overflow flags.
- instr_valid outside IDLE is ignored. The bus must hold instr until it is accepted.
- Reset mid-instruction: return to IDLE immediately, abort any pending writeback, clear the register file. No done pulse.

Optional Feature:
- Macro: ALU_ISSUE_SEQ_DIVZERO_TRAP_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - DIV with divisor 0 sets err sticky until rst and suppresses the rd writeback.
  - done still pulses.
- Undefined:
  - No err port.
  - DIV by 0 writes 0 to rd.

Test Plan:
- Reset then seed registers via ADD from r0 paths. ADD r1 = r2 + r3 with r2 = 5, r3 = 7 -> alu_opcode 00000 during EX, done 4 cycles after accept, dbg r1 = 12.
- MAC r4 with r4 = 10, r1 = 3, r2 = 4 -> MUL issued, then ADD with op2 = 10; done 5 cycles after accept; r4 = 22.
- DIV r5 = r1 / r0 -> ALU not issued; r5 = 0 (macro off), or r5 unchanged and err = 1 (macro on).
- BEQ r1, r1 with rd = 3, tgt_lo = 5'h0A -> branch_taken = 1 with done, branch_target = 8'h6A, no register change. BNE on the same operands -> branch_taken = 0.
- Write to r0 (SUB r0 = r1 - r2) -> dbg r0 = 0. Assert instr_valid during EX -> instruction not accepted until IDLE, instr_ready = 0.
- Assert rst during EX of ADD r1 -> state IDLE, r1 = 0, no done, outputs at reset values.
